// File: rtl/herloa_pkg.sv
// Shared definitions for the HERLOA approximate-adder family.
// Mode encodings and the elaboration-time segment-width check.
package herloa_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // The HERLOA low segment needs bits K-1, K-2 and K-3 to exist.
    function automatic bit k_valid(input int k);
        return k >= 3;
    endfunction

endpackage

// File: rtl/herloa_lsb_approx.sv
// HERLOA approximate low segment: K-bit OR-based sum plus carry into the upper segment.
// Latency: combinational. Backpressure: none (pure function of a, b).
// Used by every approximate-adder variant that shares this low-segment scheme.
module herloa_lsb_approx
    import herloa_pkg::*;
#(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic [K-1:0] s,
    output logic         cin
);

    logic x;
    logic c0;
    logic d1;

    assign x   = a[K-1] ^ b[K-1];
    assign c0  = a[K-2] & b[K-2];
    assign d1  = c0 & x;
    assign cin = a[K-1] & b[K-1];

    // Bit K-3 follows the same OR-with-D1 rule as the bits below it.
    always_comb begin
        s      = a | b | {K{d1}};
        s[K-1] = x | c0;
        s[K-2] = ~(~x & c0) & (a[K-2] | b[K-2]);
    end

endmodule

// File: rtl/herloa_pipe.sv
// Two-stage HERLOA/exact adder with mismatch flag and saturating error/beat counters.
// Latency: 2 cycles from accepted beat to out_valid; full throughput.
// Backpressure: valid/ready; a stalled output holds, S1 refills only as the output drains.
module herloa_pipe
    import herloa_pkg::*;
#(
    parameter int N     = 16,
    parameter int K     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N:0]       out_sum,
    output logic             out_approx,
    output logic             out_mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] beat_cnt,
    input  logic             cnt_clr
);

    generate
        if (!k_valid(K) || N < K + 1) begin : g_bad_params
            $error("herloa_pipe: requires K >= 3 and N >= K+1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [K-1:0]   lo_apx;
    logic           cin_apx;
    logic [K:0]     lo_ex_full;

    logic           s1_valid;
    logic [K-1:0]   s1_lo_apx;
    logic [K-1:0]   s1_lo_ex;
    logic           s1_cin_apx;
    logic           s1_cin_ex;
    logic [N-K-1:0] s1_a_hi;
    logic [N-K-1:0] s1_b_hi;
    logic           s1_approx;

    logic           s1_advance;
    logic           in_fire;
    logic           out_fire;
    logic [N-K:0]   up_apx;
    logic [N-K:0]   up_ex;
    logic [N:0]     sum_apx;
    logic [N:0]     sum_ex;

    herloa_lsb_approx #(.K(K)) u_lsb (
        .a   (in_a[K-1:0]),
        .b   (in_b[K-1:0]),
        .s   (lo_apx),
        .cin (cin_apx)
    );

    assign lo_ex_full = {1'b0, in_a[K-1:0]} + {1'b0, in_b[K-1:0]};

    assign s1_advance = ~out_valid | out_ready;
    assign in_ready   = ~s1_valid | s1_advance;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_lo_apx  <= '0;
            s1_lo_ex   <= '0;
            s1_cin_apx <= 1'b0;
            s1_cin_ex  <= 1'b0;
            s1_a_hi    <= '0;
            s1_b_hi    <= '0;
            s1_approx  <= MODE_EXACT;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo_apx  <= lo_apx;
                s1_lo_ex   <= lo_ex_full[K-1:0];
                s1_cin_apx <= cin_apx;
                s1_cin_ex  <= lo_ex_full[K];
                s1_a_hi    <= in_a[N-1:K];
                s1_b_hi    <= in_b[N-1:K];
                s1_approx  <= in_approx;
            end
        end
    end

    // Both upper adds run side by side so the compare needs no extra stage.
    assign up_apx  = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{(N-K){1'b0}}, s1_cin_apx};
    assign up_ex   = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{(N-K){1'b0}}, s1_cin_ex};
    assign sum_apx = {up_apx, s1_lo_apx};
    assign sum_ex  = {up_ex, s1_lo_ex};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_approx   <= MODE_EXACT;
            out_mismatch <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum      <= (s1_approx == MODE_APPROX) ? sum_apx : sum_ex;
                out_approx   <= s1_approx;
                out_mismatch <= (s1_approx == MODE_APPROX) && (sum_apx != sum_ex);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            beat_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt  <= '0;
            beat_cnt <= '0;
        end else if (out_fire) begin
            if (out_approx == MODE_APPROX && beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
            if (out_mismatch && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
